shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller and datapath for MIPS shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV).
//  Selects the shift amount from the instruction shamt field or Rs[4:0] and zero-extends it.
//  Shifts Rt by at most STEP bits per cycle, stalling the EX stage until done.
//  Sits in EX beside the ALU; the result muxes onto the ALU-result bus when Done=1.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W  5   shift-amount field width (log2 DATA_W)
//  STEP     4   max bits shifted per cycle; power of 2, 1..DATA_W
// PORTS
//  Clk       in   1       rising-edge clock
//  Reset_n   in   1       asynchronous, active-low reset
//  Start     in   1       request a shift; accepted only when Busy=0
//  Op        in   2       00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SLL)
//  Variable  in   1       1: amount=Rs[4:0] (xxxV forms); 0: amount=Shamt
//  Shamt     in   SHAMT_W instruction shamt field
//  Rs        in   DATA_W  variable-amount source; only [SHAMT_W-1:0] used
//  Rt        in   DATA_W  operand to shift
//  Flush     in   1       abort current operation (branch/exception kill)
//  Busy      out  1       operation in progress (SHIFT or DONE state)
//  Stall     out  1       hold pipeline: (Start & state==IDLE) | state==SHIFT
//  Done      out  1       one-cycle pulse; Result valid this cycle
//  Result    out  DATA_W  shifted value; holds last value until next acceptance
// BEHAVIOUR
//  - Clock: one clock; reset is asynchronous and active-low (Clk, Reset_n).
//  - Reset: state=IDLE, Busy=0, Stall=0, Done=0, Result=0, internal count/operand/op cleared.
//  - States: IDLE, SHIFT, DONE.
//  - IDLE: on Start&~Flush, capture Rt, Op, amount={zero-ext}(Variable?Rs[4:0]:Shamt).
//    amount==0 -> DONE; else -> SHIFT. Start with Flush in the same cycle is ignored.
//  - SHIFT: each cycle shift by k=min(count,STEP), count-=k; if count becomes 0 -> DONE.
//    SLL fills 0s at LSB; SRL fills 0s at MSB; SRA replicates captured bit DATA_W-1.
//  - DONE: Done=1, Result=final value, Busy=1, Stall=0; next cycle -> IDLE unconditionally.
//  - Latency: Start accepted at edge 0; Done high in cycle 1+ceil(amount/STEP)
//    (amount=0 -> cycle 1; amount=31, STEP=4 -> cycle 9).
//  - Amount is always 0..DATA_W-1; Rs[31:5] never affects the result.
//  - Start while Busy=1: ignored, no queueing; operands must be re-presented.
//  - Flush in SHIFT or DONE: next state IDLE, Done forced 0 that cycle, Result unchanged.
//  - Flush in IDLE: no effect.
//  - Reset asserted mid-operation: immediate return to reset values; no Done.
//  - Result register updates only on the SHIFT->DONE or IDLE->DONE transition.
// TESTING
//  - Reset: Reset_n=0 mid-SHIFT -> Busy=0, Done=0, Result=0 asynchronously; no Done after release.
//  - SLL: Rt=0x0000_0001, Shamt=31, Variable=0 -> Done in cycle 9, Result=0x8000_0000.
//  - SRA/SRAV: Rt=0x8000_00F0, Rs=0xFFFF_FFE4 (amount 4), Op=10, Variable=1 -> Done in cycle 2,
//    Result=0xF800_000F.
//  - SRL zero amount: Rt=0xDEAD_BEEF, Shamt=0, Op=01 -> Done in cycle 1, Result=0xDEAD_BEEF,
//    Stall high only in cycle 0.
//  - Flush: SLL amount 16, Flush in cycle 2 -> no Done; Result keeps prior value; IDLE in cycle 3.
//  - Busy ignore: Start re-pulsed in SHIFT with different Rt -> first result unaffected;
//    new Start after DONE accepted normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle MIPS shift unit (SLL/SRL/SRA and variable forms), STEP bits per cycle
module shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic               variable_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [DATA_W-1:0]  rs_i,
  input  logic [DATA_W-1:0]  rt_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               stall_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  result_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W+1)'(STEP);
  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]    opd_q, opd_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [SHAMT_W-1:0]   amt;
  logic [SHAMT_W:0]     k;
  logic [DATA_W-1:0]    shifted;
  logic                 unused_rs;
  assign unused_rs = ^rs_i[DATA_W-1:SHAMT_W];
  assign amt = variable_i ? rs_i[SHAMT_W-1:0] : shamt_i;
  assign k = ({1'b0, cnt_q} > STEP_V) ? STEP_V : {1'b0, cnt_q};
  // reserved op 11 falls through to a logical left shift
  assign shifted = (op_q == 2'b01) ? opd_q >> k :
                   (op_q == 2'b10) ? $unsigned($signed(opd_q) >>> k) :
                                     opd_q << k;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opd_d    = opd_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start_i && !flush_i) begin
        opd_d   = rt_i;
        op_d    = op_i;
        cnt_d   = amt;
        state_d = (amt == '0) ? DONE : SHIFT;
        if (amt == '0) result_d = rt_i;
      end
      SHIFT: if (flush_i) begin
        state_d = IDLE;
      end else begin
        opd_d = shifted;
        cnt_d = cnt_q - k[SHAMT_W-1:0];
        if ({1'b0, cnt_q} == k) begin
          state_d  = DONE;
          result_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opd_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opd_q    <= opd_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end
  assign busy_o   = state_q != IDLE;
  assign stall_o  = (start_i && state_q == IDLE) || state_q == SHIFT;
  assign done_o   = state_q == DONE && !flush_i;
  assign result_o = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against a one-shot shift model
module tb_shift_sequencer;
  localparam int STEP = 4;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [1:0]  op = 0;
  logic        var_sel = 0;
  logic [4:0]  shamt = 0;
  logic [31:0] rs = 0;
  logic [31:0] rt = 0;
  logic        flush = 0;
  logic        busy, stall, done;
  logic [31:0] result;
  int n_chk = 0;
  int n_pass = 0;

  shift_sequencer #(.DATA_W(32), .SHAMT_W(5), .STEP(STEP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .variable_i(var_sel),
    .shamt_i(shamt), .rs_i(rs), .rt_i(rt), .flush_i(flush),
    .busy_o(busy), .stall_o(stall), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] o, input int amt);
    logic signed [31:0] s;
    s = a;
    case (o)
      2'b01:   return a >> amt;
      2'b10:   return s >>> amt;
      default: return a << amt;
    endcase
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [1:0] o, input logic v, input string name);
    int amt, elat;
    logic [31:0] exp;
    bit got;
    amt  = v ? int'(b[4:0]) : int'(sh);
    exp  = model(a, o, amt);
    elat = 1 + (amt + STEP - 1) / STEP;
    @(negedge clk);
    rt = a; rs = b; shamt = sh; op = o; var_sel = v; start = 1;
    #1;
    n_chk++;
    if (stall !== 1'b1) $display("FAIL %s stall0 got %b want 1", name, stall); else n_pass++;
    got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      if (done === 1'b1) begin
        got = 1;
        n_chk++;
        if (c !== elat) $display("FAIL %s latency got %0d want %0d", name, c, elat); else n_pass++;
        n_chk++;
        if (result !== exp) $display("FAIL %s result got %h want %h", name, result, exp); else n_pass++;
        n_chk++;
        if (stall !== 1'b0 || busy !== 1'b1)
          $display("FAIL %s done_flags stall=%b busy=%b want 0/1", name, stall, busy);
        else n_pass++;
      end else begin
        n_chk++;
        if (stall !== 1'b1 || busy !== 1'b1)
          $display("FAIL %s shift_flags cyc %0d stall=%b busy=%b want 1/1", name, c, stall, busy);
        else n_pass++;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL %s timeout no done within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (busy !== 0 || stall !== 0 || done !== 0 || result !== 0)
      $display("FAIL reset_init busy=%b stall=%b done=%b result=%h want 0", busy, stall, done, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    do_op(32'h0000_1234, 0, 5'd0, 2'b00, 1'b0, "pre_reset");
    @(negedge clk);
    rt = 32'hFFFF_FFFF; shamt = 5'd31; op = 2'b00; var_sel = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++;
    if (busy !== 0 || done !== 0 || result !== 0)
      $display("FAIL reset_mid busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 0 || busy !== 0) $display("FAIL reset_after cyc %0d done=%b busy=%b want 0", c, done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_sll;
    do_op(32'h0000_0001, 32'h0, 5'd31, 2'b00, 1'b0, "sll31");
  endtask

  task automatic test_srav;
    do_op(32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 2'b10, 1'b1, "srav4");
    n_chk++;
    if (result !== 32'hF800_000F) $display("FAIL srav_const got %h want f800000f", result); else n_pass++;
  endtask

  task automatic test_srl_zero;
    do_op(32'hDEAD_BEEF, 32'h0, 5'd0, 2'b01, 1'b0, "srl0");
    n_chk++;
    if (result !== 32'hDEAD_BEEF) $display("FAIL srl0_const got %h want deadbeef", result); else n_pass++;
  endtask

  task automatic test_reserved;
    do_op(32'h0F0F_0003, 32'h0, 5'd9, 2'b11, 1'b0, "op11");
  endtask

  task automatic test_flush;
    logic [31:0] prior;
    do_op(32'h0000_00A5, 32'h0, 5'd3, 2'b00, 1'b0, "pre_flush");
    prior = result;
    @(negedge clk);
    rt = 32'h1234_5678; shamt = 5'd16; op = 2'b00; var_sel = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    flush = 1;
    #1;
    n_chk++;
    if (done !== 0) $display("FAIL flush_c2 done got %b want 0", done); else n_pass++;
    @(negedge clk);
    flush = 0;
    #1;
    n_chk++;
    if (busy !== 0 || result !== prior)
      $display("FAIL flush_c3 busy=%b result=%h want 0/%h", busy, result, prior);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 0 || busy !== 0) $display("FAIL flush_after cyc %0d done=%b busy=%b", c, done, busy);
      else n_pass++;
    end
    @(negedge clk);
    rt = 32'h1; shamt = 5'd0; start = 1; flush = 1;
    @(negedge clk);
    start = 0; flush = 0;
    #1;
    n_chk++;
    if (busy !== 0 || done !== 0) $display("FAIL flush_start busy=%b done=%b want 0", busy, done);
    else n_pass++;
    @(negedge clk);
    rt = 32'h77; shamt = 5'd0; start = 1;
    @(negedge clk);
    start = 0; flush = 1;
    #1;
    n_chk++;
    if (done !== 0 || busy !== 1) $display("FAIL flush_done done=%b busy=%b want 0/1", done, busy);
    else n_pass++;
    @(negedge clk);
    flush = 0;
    #1;
    n_chk++;
    if (busy !== 0) $display("FAIL flush_done_idle busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    logic [31:0] exp;
    bit got;
    exp = model(32'h0000_F00F, 2'b00, 12);
    @(negedge clk);
    rt = 32'h0000_F00F; shamt = 5'd12; op = 2'b00; var_sel = 0; start = 1;
    got = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin rt = 32'hFFFF_FFFF; shamt = 5'd1; op = 2'b01; end
      #1;
      if (done === 1'b1) begin
        got = 1;
        n_chk++;
        if (c !== 4) $display("FAIL busy_ign latency got %0d want 4", c); else n_pass++;
        n_chk++;
        if (result !== exp) $display("FAIL busy_ign result got %h want %h", result, exp); else n_pass++;
      end
    end
    start = 0;
    if (!got) begin
      n_chk++;
      $display("FAIL busy_ign timeout no done");
    end
    do_op(32'h8000_0000, 32'h0, 5'd5, 2'b10, 1'b0, "after_busy");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      do_op($urandom, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), "rand");
  endtask

  task automatic test_back_to_back;
    do_op(32'hCAFE_F00D, 32'h0000_001F, 5'd0, 2'b10, 1'b1, "b2b_a");
    do_op(32'hCAFE_F00D, 32'h0, 5'd1, 2'b01, 1'b0, "b2b_b");
    do_op(32'hCAFE_F00D, 32'hFFFF_FFE8, 5'd3, 2'b00, 1'b1, "b2b_c");
  endtask

  initial begin
    #2;
    test_reset();
    test_sll();
    test_srav();
    test_srl_zero();
    test_reserved();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
